// File: rtl/axi4_full_mem_slave.sv
// AXI4 full responder backed by a 32-bit word register array.
// Read and write channels run independent FSMs; bursts up to 256 beats.
module axi4_full_mem_slave #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned ID_W  = 4,
  parameter int unsigned AW    = 32
) (
  input  logic            s_aclk,
  input  logic            s_arst,
  input  logic [ID_W-1:0] s_axi_awid,
  input  logic [AW-1:0]   s_axi_awaddr,
  input  logic [7:0]      s_axi_awlen,
  input  logic [2:0]      s_axi_awsize,
  input  logic [1:0]      s_axi_awburst,
  input  logic            s_axi_awvalid,
  output logic            s_axi_awready,
  input  logic [31:0]     s_axi_wdata,
  input  logic [3:0]      s_axi_wstrb,
  input  logic            s_axi_wlast,
  input  logic            s_axi_wvalid,
  output logic            s_axi_wready,
  output logic [ID_W-1:0] s_axi_bid,
  output logic [1:0]      s_axi_bresp,
  output logic            s_axi_bvalid,
  input  logic            s_axi_bready,
  input  logic [ID_W-1:0] s_axi_arid,
  input  logic [AW-1:0]   s_axi_araddr,
  input  logic [7:0]      s_axi_arlen,
  input  logic [2:0]      s_axi_arsize,
  input  logic [1:0]      s_axi_arburst,
  input  logic            s_axi_arvalid,
  output logic            s_axi_arready,
  output logic [ID_W-1:0] s_axi_rid,
  output logic [31:0]     s_axi_rdata,
  output logic [1:0]      s_axi_rresp,
  output logic            s_axi_rlast,
  output logic            s_axi_rvalid,
  input  logic            s_axi_rready
);

  localparam int unsigned WORD_W = AW - 2;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  logic [31:0] mem [DEPTH];

  // Byte offset bits are ignored by word addressing.
  logic unused_ok;
  assign unused_ok = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // ---------------- write channel ----------------
  w_state_t          w_state, w_next;
  logic [WORD_W-1:0] w_word;
  logic [7:0]        w_len, w_cnt;
  logic              w_incr, w_berr, w_err;
  logic              aw_hs, w_hs, b_hs, w_last_beat, w_in_range, w_err_now;

  assign aw_hs       = s_axi_awvalid & s_axi_awready;
  assign w_hs        = s_axi_wvalid & s_axi_wready;
  assign b_hs        = s_axi_bvalid & s_axi_bready;
  assign w_last_beat = (w_cnt == w_len);
  assign w_in_range  = (w_word < WORD_W'(DEPTH));
  assign w_err_now   = w_err | ~w_in_range | (s_axi_wlast != w_last_beat);

  always_ff @(posedge s_aclk) begin
    if (s_arst) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs)               w_next = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) w_next = W_RESP;
      W_RESP:  if (b_hs)                w_next = W_IDLE;
      default:                          w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge s_aclk) begin
    if (s_arst) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bid     <= '0;
      s_axi_bresp   <= RESP_OKAY;
      w_word        <= '0;
      w_len         <= '0;
      w_cnt         <= '0;
      w_incr        <= 1'b0;
      w_berr        <= 1'b0;
      w_err         <= 1'b0;
    end else begin
      s_axi_awready <= (w_next == W_IDLE);
      s_axi_wready  <= (w_next == W_DATA);
      s_axi_bvalid  <= (w_next == W_RESP);
      if (aw_hs) begin
        s_axi_bid <= s_axi_awid;
        w_word    <= s_axi_awaddr[AW-1:2];
        w_len     <= s_axi_awlen;
        w_cnt     <= '0;
        w_incr    <= (s_axi_awburst == 2'b01);
        w_berr    <= (s_axi_awsize != 3'b010) | s_axi_awburst[1];
        w_err     <= (s_axi_awsize != 3'b010) | s_axi_awburst[1];
      end
      if (w_hs) begin
        w_cnt <= w_cnt + 8'd1;
        w_err <= w_err_now;
        if (w_incr) w_word <= w_word + WORD_W'(1);
        if (w_last_beat) s_axi_bresp <= w_err_now ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // Memory is never cleared; a beat landing on a reset edge is discarded.
  always_ff @(posedge s_aclk) begin
    if (!s_arst && w_hs && !w_berr && w_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (s_axi_wstrb[b]) mem[w_word[IDX_W-1:0]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_t          r_state, r_next;
  logic [WORD_W-1:0] r_word, f_word;
  logic [7:0]        r_len, r_cnt;
  logic              r_incr, r_berr, ar_berr, f_berr, f_ok;
  logic [31:0]       f_data;
  logic              ar_hs, r_hs;

  assign ar_hs   = s_axi_arvalid & s_axi_arready;
  assign r_hs    = s_axi_rvalid & s_axi_rready;
  assign ar_berr = (s_axi_arsize != 3'b010) | s_axi_arburst[1];

  // Word fetched on the next load: start word in IDLE, following word in DATA.
  always_comb begin
    f_word = s_axi_araddr[AW-1:2];
    f_berr = ar_berr;
    if (r_state == R_DATA) begin
      f_word = r_incr ? (r_word + WORD_W'(1)) : r_word;
      f_berr = r_berr;
    end
    f_ok   = !f_berr && (f_word < WORD_W'(DEPTH));
    f_data = f_ok ? mem[f_word[IDX_W-1:0]] : 32'h0;
  end

  always_ff @(posedge s_aclk) begin
    if (s_arst) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs)                r_next = R_DATA;
      R_DATA:  if (r_hs && s_axi_rlast)  r_next = R_IDLE;
      default:                           r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge s_aclk) begin
    if (s_arst) begin
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rid     <= '0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rlast   <= 1'b0;
      r_word        <= '0;
      r_len         <= '0;
      r_cnt         <= '0;
      r_incr        <= 1'b0;
      r_berr        <= 1'b0;
    end else begin
      s_axi_arready <= (r_next == R_IDLE);
      s_axi_rvalid  <= (r_next == R_DATA);
      if (ar_hs) begin
        s_axi_rid   <= s_axi_arid;
        s_axi_rdata <= f_data;
        s_axi_rresp <= f_ok ? RESP_OKAY : RESP_SLVERR;
        s_axi_rlast <= (s_axi_arlen == 8'd0);
        r_word      <= f_word;
        r_len       <= s_axi_arlen;
        r_cnt       <= '0;
        r_incr      <= (s_axi_arburst == 2'b01);
        r_berr      <= ar_berr;
      end else if (r_hs && !s_axi_rlast) begin
        s_axi_rdata <= f_data;
        s_axi_rresp <= f_ok ? RESP_OKAY : RESP_SLVERR;
        s_axi_rlast <= ((r_cnt + 8'd1) == r_len);
        r_word      <= f_word;
        r_cnt       <= r_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_axi4_full_mem_slave.sv
// Scoreboard bench for axi4_full_mem_slave: expected B/R beats are queued
// from a behavioural memory model when stimulus is issued and checked on arrival.
module tb_axi4_full_mem_slave;

  localparam int DEPTH = 1024;

  logic        s_aclk, s_arst;
  logic [3:0]  s_axi_awid;
  logic [31:0] s_axi_awaddr;
  logic [7:0]  s_axi_awlen;
  logic [2:0]  s_axi_awsize;
  logic [1:0]  s_axi_awburst;
  logic        s_axi_awvalid, s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic [3:0]  s_axi_bid;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid, s_axi_bready;
  logic [3:0]  s_axi_arid;
  logic [31:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic [1:0]  s_axi_arburst;
  logic        s_axi_arvalid, s_axi_arready;
  logic [3:0]  s_axi_rid;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;

  axi4_full_mem_slave #(.DEPTH(DEPTH), .ID_W(4), .AW(32)) dut (
    .s_aclk(s_aclk), .s_arst(s_arst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  initial s_aclk = 1'b0;
  always #5 s_aclk = ~s_aclk;

  typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } rbeat_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } bresp_t;

  rbeat_t      r_exp[$];
  bresp_t      b_exp[$];
  logic [31:0] model [int];
  logic [31:0] wq_data[$];
  logic [3:0]  wq_strb[$];
  int          tests_run = 0;
  int          tests_failed = 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge s_aclk); #1;
  endtask

  task automatic aw_handshake(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst, output bit ok);
    int n;
    ok = 0; n = 0;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
    s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    while (!ok && n < 100) begin ok = s_axi_awready; tick(); n++; end
    s_axi_awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last, output bit ok);
    int n;
    ok = 0; n = 0;
    s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wlast = last; s_axi_wvalid = 1'b1;
    while (!ok && n < 100) begin ok = s_axi_wready; tick(); n++; end
    s_axi_wvalid = 1'b0;
  endtask

  // Write burst from wq_data/wq_strb; bad_last >= 0 moves wlast to that beat.
  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input int bad_last, input bit gaps, input int bdelay);
    bit berr, err, ok, lst;
    logic [29:0] word;
    logic [31:0] cur;
    bresp_t e;
    int n;
    berr = (size != 3'b010) || burst[1];
    err  = berr;
    word = addr[31:2];
    for (int i = 0; i <= int'(len); i++) begin
      lst = (bad_last >= 0) ? (i == bad_last) : (i == int'(len));
      if (int'(word) >= DEPTH) err = 1;
      else if (!berr) begin
        cur = model.exists(int'(word)) ? model[int'(word)] : 32'h0;
        for (int b = 0; b < 4; b++) if (wq_strb[i][b]) cur[8*b +: 8] = wq_data[i][8*b +: 8];
        model[int'(word)] = cur;
      end
      if (lst != (i == int'(len))) err = 1;
      if (burst == 2'b01) word = word + 30'd1;
    end
    b_exp.push_back('{id: id, resp: err ? 2'b10 : 2'b00});

    aw_handshake(id, addr, len, size, burst, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL aw_timeout: awready=%b expected 1", s_axi_awready); void'(b_exp.pop_front()); return; end
    for (int i = 0; i <= int'(len); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      lst = (bad_last >= 0) ? (i == bad_last) : (i == int'(len));
      w_beat(wq_data[i], wq_strb[i], lst, ok);
      if (!ok) begin
        tests_run++; tests_failed++;
        $display("FAIL w_timeout: beat %0d wready=%b expected 1", i, s_axi_wready);
        void'(b_exp.pop_front()); return;
      end
    end

    n = 0;
    while (!s_axi_bvalid && n < 200) begin tick(); n++; end
    tests_run++;
    if (!s_axi_bvalid) begin tests_failed++; $display("FAIL b_timeout: bvalid=0 expected 1"); void'(b_exp.pop_front()); return; end
    if (bdelay > 0) begin
      repeat (bdelay) tick();
      tests_run++;
      if (s_axi_bvalid !== 1'b1) begin tests_failed++; $display("FAIL b_hold: bvalid=%b expected 1", s_axi_bvalid); end
    end
    e = b_exp.pop_front();
    tests_run++;
    if (s_axi_bid !== e.id || s_axi_bresp !== e.resp) begin
      tests_failed++;
      $display("FAIL b_resp: got bid=%h bresp=%b, expected bid=%h bresp=%b", s_axi_bid, s_axi_bresp, e.id, e.resp);
    end
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    tests_run++;
    if (s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b1) begin
      tests_failed++;
      $display("FAIL b_done: got bvalid=%b awready=%b, expected 0 1", s_axi_bvalid, s_axi_awready);
    end
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int stall_beat, input int stall_cyc, input bit check_lat, output int gaps);
    bit berr, ok;
    logic [29:0] word;
    logic [31:0] hold;
    rbeat_t e;
    int n;
    gaps = 0;
    berr = (size != 3'b010) || burst[1];
    word = addr[31:2];
    for (int i = 0; i <= int'(len); i++) begin
      if (berr || int'(word) >= DEPTH)
        r_exp.push_back('{id: id, data: 32'h0, resp: 2'b10, last: (i == int'(len))});
      else
        r_exp.push_back('{id: id, data: model[int'(word)], resp: 2'b00, last: (i == int'(len))});
      if (burst == 2'b01) word = word + 30'd1;
    end

    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
    s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    ok = 0; n = 0;
    while (!ok && n < 100) begin ok = s_axi_arready; tick(); n++; end
    s_axi_arvalid = 1'b0;
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL ar_timeout: arready=0 expected 1"); r_exp.delete(); return; end
    if (check_lat) begin
      tests_run++;
      if (s_axi_rvalid !== 1'b1) begin tests_failed++; $display("FAIL r_latency: rvalid=%b one cycle after AR, expected 1", s_axi_rvalid); end
    end

    s_axi_rready = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (!s_axi_rvalid && n < 200) begin tick(); n++; end
      if (!s_axi_rvalid) begin
        tests_run++; tests_failed++;
        $display("FAIL r_timeout: beat %0d rvalid=0 expected 1", i);
        r_exp.delete(); s_axi_rready = 1'b0; return;
      end
      if (i > 0) gaps += n;
      if (i == stall_beat && stall_cyc > 0) begin
        s_axi_rready = 1'b0;
        hold = s_axi_rdata;
        for (int c = 0; c < stall_cyc; c++) begin
          tick();
          tests_run++;
          if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== hold) begin
            tests_failed++;
            $display("FAIL r_stall: got rvalid=%b rdata=%h, expected 1 %h", s_axi_rvalid, s_axi_rdata, hold);
          end
        end
        s_axi_rready = 1'b1;
      end
      e = r_exp.pop_front();
      tests_run++;
      if (s_axi_rid !== e.id || s_axi_rdata !== e.data || s_axi_rresp !== e.resp || s_axi_rlast !== e.last) begin
        tests_failed++;
        $display("FAIL r_beat%0d: got id=%h data=%h resp=%b last=%b, expected id=%h data=%h resp=%b last=%b",
                 i, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, e.id, e.data, e.resp, e.last);
      end
      tick();
    end
    s_axi_rready = 1'b0;
    tests_run++;
    if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1) begin
      tests_failed++;
      $display("FAIL r_done: got rvalid=%b arready=%b, expected 0 1", s_axi_rvalid, s_axi_arready);
    end
  endtask

  task automatic fill_wq(input logic [31:0] base, input int n, input logic [3:0] strb);
    wq_data.delete(); wq_strb.delete();
    for (int i = 0; i < n; i++) begin wq_data.push_back(base + 32'(i)); wq_strb.push_back(strb); end
  endtask

  task automatic test_reset();
    s_arst = 1'b1;
    repeat (3) tick();
    tests_run++;
    if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast} !== 6'b0 ||
        s_axi_bid !== 4'h0 || s_axi_rid !== 4'h0 || s_axi_rdata !== 32'h0 ||
        s_axi_bresp !== 2'b00 || s_axi_rresp !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_values: aw=%b w=%b b=%b ar=%b r=%b rlast=%b bid=%h rid=%h rdata=%h, expected all 0",
               s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast,
               s_axi_bid, s_axi_rid, s_axi_rdata);
    end
    s_arst = 1'b0;
    tests_run++;
    if (s_axi_awready !== 1'b0) begin tests_failed++; $display("FAIL reset_early_ready: awready=%b expected 0", s_axi_awready); end
    tick();
    tests_run++;
    if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release: awready=%b arready=%b expected 1 1", s_axi_awready, s_axi_arready);
    end
  endtask

  task automatic test_single();
    int g;
    wq_data = '{32'hDEADBEEF}; wq_strb = '{4'hF};
    write_burst(4'h3, 32'h10, 8'd0, 3'b010, 2'b01, -1, 1'b0, 2);
    read_burst(4'h6, 32'h10, 8'd0, 3'b010, 2'b01, -1, 0, 1'b1, g);
  endtask

  task automatic test_incr_burst();
    int g;
    fill_wq(32'd1, 8, 4'hF);
    write_burst(4'h1, 32'h100, 8'd7, 3'b010, 2'b01, -1, 1'b1, 0);
    read_burst(4'h2, 32'h100, 8'd7, 3'b010, 2'b01, 2, 3, 1'b1, g);
  endtask

  task automatic test_strobe_fixed();
    int g;
    wq_data = '{32'hFFFFFFFF}; wq_strb = '{4'hF};
    write_burst(4'h4, 32'h20, 8'd0, 3'b010, 2'b01, -1, 1'b0, 0);
    wq_data = '{32'h11223344, 32'hAABBCCDD}; wq_strb = '{4'b0001, 4'b1000};
    write_burst(4'h5, 32'h20, 8'd1, 3'b010, 2'b00, -1, 1'b0, 0);
    r_exp.delete();
    read_burst(4'h7, 32'h20, 8'd0, 3'b010, 2'b01, -1, 0, 1'b0, g);
    tests_run++;
    if (model[8] !== 32'hAAFFFF44) begin tests_failed++; $display("FAIL strobe_model: got %h expected aaffff44", model[8]); end
  endtask

  task automatic test_errors();
    int g;
    wq_data = '{32'h0BADF00D}; wq_strb = '{4'hF};
    write_burst(4'h1, 32'((DEPTH - 1) * 4), 8'd0, 3'b010, 2'b01, -1, 1'b0, 0);
    read_burst(4'h8, 32'((DEPTH - 1) * 4), 8'd1, 3'b010, 2'b01, -1, 0, 1'b0, g);
    wq_data = '{32'h12345678}; wq_strb = '{4'hF};
    write_burst(4'h2, 32'h30, 8'd0, 3'b010, 2'b01, -1, 1'b0, 0);
    wq_data = '{32'hFFFF0000}; wq_strb = '{4'hF};
    write_burst(4'h9, 32'h30, 8'd0, 3'b001, 2'b01, -1, 1'b0, 0);
    read_burst(4'h3, 32'h30, 8'd0, 3'b010, 2'b01, -1, 0, 1'b0, g);
    fill_wq(32'h5000_0000, 2, 4'hF);
    write_burst(4'hB, 32'h40, 8'd1, 3'b010, 2'b01, 0, 1'b0, 0);
    read_burst(4'hC, 32'h10, 8'd1, 3'b010, 2'b10, -1, 0, 1'b1, g);
  endtask

  task automatic test_concurrency();
    int g;
    fill_wq(32'hC000_0000, 16, 4'hF);
    write_burst(4'h1, 32'h800, 8'd15, 3'b010, 2'b01, -1, 1'b0, 0);
    fill_wq(32'hD000_0000, 16, 4'hF);
    g = -1;
    fork
      write_burst(4'h9, 32'h400, 8'd15, 3'b010, 2'b01, -1, 1'b0, 0);
      read_burst(4'hA, 32'h800, 8'd15, 3'b010, 2'b01, -1, 0, 1'b1, g);
    join
    tests_run++;
    if (g !== 0) begin tests_failed++; $display("FAIL r_throughput: %0d idle cycles between beats, expected 0", g); end
    read_burst(4'hD, 32'h400, 8'd15, 3'b010, 2'b01, -1, 0, 1'b0, g);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int g;
    fill_wq(32'hA000_0000, 8, 4'hF);
    write_burst(4'h3, 32'h600, 8'd7, 3'b010, 2'b01, -1, 1'b0, 0);
    aw_handshake(4'h5, 32'h600, 8'd7, 3'b010, 2'b01, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL rm_aw_timeout: awready=0 expected 1"); end
    for (int i = 0; i < 3; i++) begin
      w_beat(32'hB000_0000 + 32'(i), 4'hF, 1'b0, ok);
      model[384 + i] = 32'hB000_0000 + 32'(i);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL rm_w_timeout: beat %0d wready=0 expected 1", i); end
    end
    s_axi_wdata = 32'hB000_0003; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b1;
    s_arst = 1'b1;
    tick();
    tests_run++;
    if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid} !== 5'b0 || s_axi_bid !== 4'h0) begin
      tests_failed++;
      $display("FAIL rm_reset: aw=%b w=%b b=%b ar=%b r=%b bid=%h, expected all 0",
               s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_bid);
    end
    s_arst = 1'b0; s_axi_wvalid = 1'b0;
    tick();
    tests_run++;
    if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rm_release: awready=%b arready=%b expected 1 1", s_axi_awready, s_axi_arready);
    end
    read_burst(4'hE, 32'h600, 8'd7, 3'b010, 2'b01, -1, 0, 1'b0, g);
  endtask

  initial begin
    s_arst = 1'b1;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0; s_axi_awburst = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0; s_axi_arburst = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;
    test_reset();
    test_single();
    test_incr_burst();
    test_strobe_fixed();
    test_errors();
    test_concurrency();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
